fetch_sequencer: RTL
====================

# fetch_sequencer

Controller for the instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter and sequences a req/ack instruction-memory port. Applies branch redirects from Execute and decode stalls from the hazard logic, and drives the Fetch→Decode pipeline register. The handshake tolerates multi-cycle memory and still sustains one instruction per cycle when memory acks immediately.

## Interface
- RESET_PC, 32'h00000000, PC value loaded at reset
- BOOT_WAIT, 4, idle cycles after reset release before the first request (range 1–15)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- stall_de  in  1  Decode cannot accept; hold Decode register
- PCsrcEx  in  1  branch/jump taken in Execute
- PCtrgEx  in  32  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equals current PC
- imem_ack  in  1  imem_rdata valid this cycle; completes request
- imem_rdata  in  32  instruction word
- InstrDe  out  32  instruction to Decode
- PCDe  out  32  PC of InstrDe
- PCplus4De  out  32  PCDe + 4
- valid_de  out  1  Decode register holds a real instruction

## Operation
- Reset value of every output: InstrDe, PCDe and PCplus4De are 0; valid_de and imem_req are 0; imem_addr is RESET_PC.
- After reset: state BOOT, PC is RESET_PC, boot counter is 0.
- Event priority: rst, then PCsrcEx, then stall_de, then imem_ack.
- States:
  - BOOT: imem_req=0. Counter increments each cycle. At BOOT_WAIT−1 → REQ.
  - REQ: imem_req=1, imem_addr=PC.
    - ack & !stall_de: Decode regs ← {rdata, PC, PC+4}, valid_de=1, PC ← PC+4, stay in REQ.
    - ack & stall_de: skid ← {rdata, PC, PC+4}, PC ← PC+4 → HOLD.
    - No ack: hold. imem_addr must stay stable until ack.
  - HOLD: imem_req=0. When stall_de=0: Decode regs ← skid, valid_de=1 → REQ.
  - DRAIN: entered on a redirect while a request is outstanding without ack. imem_req=1 at the old address. On ack: data discarded, PC ← stored target → REQ.
- A request is never withdrawn before ack.
- Redirect (PCsrcEx=1) effects:
  - Decode regs → 0 and valid_de → 0 (NOP injected), even if stall_de=1.
  - Skid buffer invalidated.
  - BOOT: PC ← PCtrgEx; boot counter continues.
  - REQ with ack in the same cycle: rdata dropped, PC ← PCtrgEx, stay in REQ.
  - REQ without ack: target latched → DRAIN.
  - HOLD: PC ← PCtrgEx → REQ.
  - DRAIN: latched target overwritten (last redirect wins). If ack arrives in the same cycle, PC ← new PCtrgEx → REQ.
- stall_de=1 with no redirect: Decode regs and valid_de hold their values.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 0. PC[1:0] is forced to 0 on every load.

## Timing
- Decode regs and PC update on the rising clk edge of the ack cycle. InstrDe is visible the cycle after ack (latency 1).
- imem_req and imem_addr are decoded from registered state and PC only. They have no combinational path from any input.
- Redirect penalty: a redirect at edge N produces a request for PCtrgEx in cycle N+1 (REQ case) or in the cycle after the drain ack (DRAIN case).
- Throughput: 1 instruction/cycle while imem_ack=1 and stall_de=0.
- Asynchronous reset mid-request aborts immediately. The memory must tolerate the abandoned request.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0 and saturating at 32'hFFFFFFFF.
  - stall_cnt increments each cycle with stall_de=1 and valid_de=1.
  - flush_cnt increments each cycle with PCsrcEx=1.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg holds:
  - the state typedef {BOOT, REQ, HOLD, DRAIN};
  - the NOP constant 32'h00000000;
  - the PC increment constant 32'h00000004;
  - the default RESET_PC.
- One sub-module, fetch_skid: a one-entry {instr, pc, pc4, valid} buffer with load, unload and flush inputs.

## Test plan
- Reset release, imem_ack tied 1, RESET_PC=0, BOOT_WAIT=4 → imem_req rises 4 cycles after rst↑. Then PCDe = 0, 4, 8 … on consecutive cycles with valid_de=1.
- ack 3 cycles after req, stall_de=0 → imem_addr is stable for all 3 cycles. InstrDe updates one cycle after the ack, and PC advances by 4 per transaction.
- stall_de=1 for 2 cycles while ack=1 → Decode regs hold. The word is captured into the skid, imem_req=0 during HOLD, and the word appears on InstrDe the cycle after stall_de falls. No instruction is lost or duplicated.
- PCsrcEx=1, PCtrgEx=32'h40, in the same cycle as ack → valid_de=0 and InstrDe=0 the next cycle, then imem_addr=32'h40.
- PCsrcEx with PCtrgEx=32'h80, outstanding request, ack 2 cycles later; second PCsrcEx with PCtrgEx=32'hC0 during DRAIN → drained word is discarded and the next imem_addr is 32'hC0.
- PC at 32'hFFFFFFFC, ack → next imem_addr=0 and PCplus4De=0. With FETCH_PERF_CNT_EN, 3 flushes give flush_cnt=3.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Types and constants shared by the instruction-fetch stage:
//                sequencer state encoding, NOP word, PC increment, default
//                reset PC and a PC alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'h0000_0004;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Word-align a PC value; every PC load passes through here.
    function automatic logic [31:0] pc_align(input logic [31:0] value);
        return value & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid
//  Description : One-entry {instr, pc, pc4, valid} buffer catching a fetched
//                word that Decode cannot accept yet. Flush wins over load,
//                load wins over unload.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_skid
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        valid
);

    // Capture on load; the payload is kept after unload/flush, only valid drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr <= NOP;
            pc    <= 32'h0;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : MIPS fetch-stage controller. Owns the PC, runs a req/ack
//                instruction-memory port, applies Execute redirects and
//                Decode stalls, and drives the Fetch->Decode register.
//                Optional macro FETCH_PERF_CNT_EN adds saturating stall and
//                flush counters (stall_cnt, flush_cnt).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BOOT_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_de,
    input  logic        PCsrcEx,
    input  logic [31:0] PCtrgEx,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrDe,
    output logic [31:0] PCDe,
    output logic [31:0] PCplus4De,
    output logic        valid_de
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic [3:0]   boot_cnt;
    logic         boot_done;
    logic         skid_load;
    logic         skid_unload;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_pc4;
    logic         skid_valid;

    assign pc_plus4  = pc + PC_INC;
    assign boot_done = (boot_cnt == 4'(BOOT_WAIT - 1));
    assign imem_addr = pc;

    // A stalled ack parks the word in the skid; HOLD releases it when Decode frees up.
    assign skid_load   = (state == REQ)  && imem_ack && stall_de && !PCsrcEx;
    assign skid_unload = (state == HOLD) && !stall_de && !PCsrcEx;

    fetch_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .unload   (skid_unload),
        .flush    (PCsrcEx),
        .instr_in (imem_rdata),
        .pc_in    (pc),
        .pc4_in   (pc_plus4),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .pc4      (skid_pc4),
        .valid    (skid_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT;
        else      state <= state_next;
    end

    // Next-state logic; redirect outranks stall, stall outranks ack.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:  if (boot_done) state_next = REQ;
            REQ: begin
                if (PCsrcEx)                   state_next = imem_ack ? REQ : DRAIN;
                else if (imem_ack && stall_de) state_next = HOLD;
            end
            HOLD:  if (PCsrcEx || !stall_de) state_next = REQ;
            DRAIN: if (imem_ack) state_next = REQ;
            default: state_next = BOOT;
        endcase
    end

    // Memory request is a pure decode of state, never of inputs.
    always_comb begin
        imem_req = (state == REQ) || (state == DRAIN);
    end

    // PC, pending redirect target and boot counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= pc_align(RESET_PC);
            target   <= pc_align(RESET_PC);
            boot_cnt <= 4'd0;
        end else begin
            case (state)
                BOOT: begin
                    boot_cnt <= boot_cnt + 4'd1;
                    if (PCsrcEx) pc <= pc_align(PCtrgEx);
                end
                REQ: begin
                    if (PCsrcEx) begin
                        if (imem_ack) pc     <= pc_align(PCtrgEx);
                        else          target <= pc_align(PCtrgEx);
                    end else if (imem_ack) begin
                        pc <= pc_plus4;
                    end
                end
                HOLD: begin
                    if (PCsrcEx) pc <= pc_align(PCtrgEx);
                end
                DRAIN: begin
                    // The outstanding word is dropped; the newest target wins.
                    if (PCsrcEx) begin
                        target <= pc_align(PCtrgEx);
                        if (imem_ack) pc <= pc_align(PCtrgEx);
                    end else if (imem_ack) begin
                        pc <= target;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fetch->Decode register: NOP on redirect, hold on stall, bubble when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrDe   <= NOP;
            PCDe      <= 32'h0;
            PCplus4De <= 32'h0;
            valid_de  <= 1'b0;
        end else if (PCsrcEx) begin
            InstrDe   <= NOP;
            PCDe      <= 32'h0;
            PCplus4De <= 32'h0;
            valid_de  <= 1'b0;
        end else if (!stall_de) begin
            if ((state == REQ) && imem_ack) begin
                InstrDe   <= imem_rdata;
                PCDe      <= pc;
                PCplus4De <= pc_plus4;
                valid_de  <= 1'b1;
            end else if (state == HOLD) begin
                InstrDe   <= skid_instr;
                PCDe      <= skid_pc;
                PCplus4De <= skid_pc4;
                valid_de  <= skid_valid;
            end else begin
                valid_de  <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of stalled-valid cycles and redirect cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 32'h0;
            flush_cnt <= 32'h0;
        end else begin
            if (stall_de && valid_de && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (PCsrcEx && (flush_cnt != 32'hFFFF_FFFF))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
